// File: rtl/apb_master_arbiter.sv
// Round-robin arbiter sharing one APB master port among NUM_REQ requesters; grant->SETUP->ACCESS->rsp, 3 cycles at zero wait.
// Requesters hold req_valid until granted; slave wait states stall the port, bounded by an optional wait-state timeout.
module apb_master_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                  PCLK,
   input  logic                  PRESET,
   input  logic [NUM_REQ-1:0]    req_valid,
   input  logic [NUM_REQ-1:0]    req_write,
   input  logic [NUM_REQ*32-1:0] req_addr,
   input  logic [NUM_REQ*32-1:0] req_wdata,
   output logic [NUM_REQ-1:0]    req_gnt,
   output logic [NUM_REQ-1:0]    rsp_valid,
   output logic [31:0]           rsp_rdata,
   output logic                  rsp_err,
   output logic                  timeout_evt,
   output logic                  PSEL,
   output logic                  PENABLE,
   output logic [31:0]           PADDR,
   output logic                  PWRITE,
   output logic [31:0]           PWDATA,
   input  logic                  PREADY,
   input  logic [31:0]           PRDATA,
   input  logic                  PSLVERR
);
   localparam int PW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CW      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam int TO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } state_t;

   typedef struct packed {
      logic        write;
      logic [31:0] addr;
      logic [31:0] wdata;
   } xfer_t;

   state_t             state_q, state_d;
   xfer_t              xfer_q, xfer_d;
   logic [PW-1:0]      owner_q, owner_d;
   logic [PW-1:0]      rr_ptr_q, rr_ptr_d;
   logic [CW-1:0]      wait_cnt_q, wait_cnt_d;
   logic               psel_q, psel_d;
   logic               penable_q, penable_d;
   logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
   logic [31:0]        rsp_rdata_q, rsp_rdata_d;
   logic               rsp_err_q, rsp_err_d;
   logic               timeout_evt_q, timeout_evt_d;

   logic               arb_en;
   logic               found;
   logic [PW-1:0]      winner;
   logic               timeout_hit;
   int                 scan_idx;

   // First pending requester at or after rr_ptr, wrapping at NUM_REQ-1.
   always_comb begin
      found    = 1'b0;
      winner   = '0;
      scan_idx = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         scan_idx = int'(rr_ptr_q) + i;
         if (scan_idx >= NUM_REQ) begin
            scan_idx = scan_idx - NUM_REQ;
         end
         if (!found && req_valid[PW'(scan_idx)]) begin
            found  = 1'b1;
            winner = PW'(scan_idx);
         end
      end
   end

   always_comb begin
      arb_en  = !PRESET && ((state_q == IDLE) || ((state_q == ACCESS) && PREADY));
      req_gnt = '0;
      if (arb_en && found) begin
         req_gnt[winner] = 1'b1;
      end
   end

   assign timeout_hit = (TIMEOUT_CYCLES > 0) && (state_q == ACCESS) && !PREADY &&
                        (wait_cnt_q == CW'(TO_LAST));

   always_comb begin
      state_d       = state_q;
      xfer_d        = xfer_q;
      owner_d       = owner_q;
      rr_ptr_d      = rr_ptr_q;
      wait_cnt_d    = '0;
      rsp_valid_d   = '0;
      rsp_rdata_d   = '0;
      rsp_err_d     = 1'b0;
      timeout_evt_d = 1'b0;

      if (arb_en && found) begin
         xfer_d.write = req_write[winner];
         xfer_d.addr  = req_addr[32*int'(winner) +: 32];
         xfer_d.wdata = req_wdata[32*int'(winner) +: 32];
         owner_d      = winner;
         rr_ptr_d     = (winner == PW'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (arb_en && found) begin
               state_d = SETUP;
            end
         end
         SETUP: begin
            state_d = ACCESS;
         end
         ACCESS: begin
            if (PREADY) begin
               rsp_valid_d[owner_q] = 1'b1;
               rsp_err_d            = PSLVERR;
               rsp_rdata_d          = xfer_q.write ? 32'h0 : PRDATA;
               state_d              = found ? SETUP : IDLE;
            end else if (timeout_hit) begin
               // Hung slave: release the bus and report an error without arbitrating.
               rsp_valid_d[owner_q] = 1'b1;
               rsp_err_d            = 1'b1;
               timeout_evt_d        = 1'b1;
               state_d              = IDLE;
            end else begin
               wait_cnt_d = (wait_cnt_q == '1) ? wait_cnt_q : wait_cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      psel_d    = (state_d != IDLE);
      penable_d = (state_d == ACCESS);
   end

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state_q       <= IDLE;
         xfer_q        <= '0;
         owner_q       <= '0;
         rr_ptr_q      <= '0;
         wait_cnt_q    <= '0;
         psel_q        <= 1'b0;
         penable_q     <= 1'b0;
         rsp_valid_q   <= '0;
         rsp_rdata_q   <= '0;
         rsp_err_q     <= 1'b0;
         timeout_evt_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         xfer_q        <= xfer_d;
         owner_q       <= owner_d;
         rr_ptr_q      <= rr_ptr_d;
         wait_cnt_q    <= wait_cnt_d;
         psel_q        <= psel_d;
         penable_q     <= penable_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_rdata_q   <= rsp_rdata_d;
         rsp_err_q     <= rsp_err_d;
         timeout_evt_q <= timeout_evt_d;
      end
   end

   assign PSEL        = psel_q;
   assign PENABLE     = penable_q;
   assign PADDR       = xfer_q.addr;
   assign PWRITE      = xfer_q.write;
   assign PWDATA      = xfer_q.wdata;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_rdata   = rsp_rdata_q;
   assign rsp_err     = rsp_err_q;
   assign timeout_evt = timeout_evt_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Bench for apb_master_arbiter: transfer-level timing model (grant, SETUP, ACCESS span, response) versus the DUT, cycle by cycle.
module tb_apb_master_arbiter;
   localparam int NR = 4;
   localparam int TO = 16;

   logic             PCLK = 1'b0;
   logic             PRESET;
   logic [NR-1:0]    req_valid, req_write, req_gnt, rsp_valid;
   logic [NR*32-1:0] req_addr, req_wdata;
   logic [31:0]      rsp_rdata, PADDR, PWDATA, PRDATA;
   logic             rsp_err, timeout_evt, PSEL, PENABLE, PWRITE, PREADY, PSLVERR;

   apb_master_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYCLES(TO)) dut (
      .PCLK        (PCLK),
      .PRESET      (PRESET),
      .req_valid   (req_valid),
      .req_write   (req_write),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .req_gnt     (req_gnt),
      .rsp_valid   (rsp_valid),
      .rsp_rdata   (rsp_rdata),
      .rsp_err     (rsp_err),
      .timeout_evt (timeout_evt),
      .PSEL        (PSEL),
      .PENABLE     (PENABLE),
      .PADDR       (PADDR),
      .PWRITE      (PWRITE),
      .PWDATA      (PWDATA),
      .PREADY      (PREADY),
      .PRDATA      (PRDATA),
      .PSLVERR     (PSLVERR)
   );

   always #5 PCLK = ~PCLK;

   int n_chk = 0;
   int n_err = 0;
   int cyc   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s @cycle %0d: got %h, want %h", tag, cyc, got, exp);
      end
   endtask

   // Requester side: pending requests and their fields.
   bit          pend [NR];
   bit          p_wr [NR];
   logic [31:0] p_addr [NR];
   logic [31:0] p_wdata [NR];

   // Transfer in flight: granted at g_cyc, last ACCESS cycle at end_cyc.
   bit          busy;
   int          g_cyc, end_cyc, own;
   bit          to_x, x_wr;
   // Pending response.
   bit          rsp_due, rsp_t, rsp_e;
   int          rsp_cyc, rsp_own;
   logic [31:0] rsp_d;
   // Port-visible transfer fields and round-robin pointer.
   int          rr;
   logic [31:0] sh_addr, sh_wdata;
   bit          sh_wr;
   // Stimulus controls.
   int          req_pct;
   int          wait_q[$];
   bit          force_err;
   bit          rst_now;

   function automatic int rand_wait();
      int r;
      r = $urandom_range(19);
      if (r == 0) return TO + 3;
      if (r == 1) return TO - 1;
      if (r == 2) return TO;
      return $urandom_range(3);
   endfunction

   task automatic drive_req();
      for (int i = 0; i < NR; i++) begin
         req_valid[i]            = pend[i];
         req_write[i]            = p_wr[i];
         req_addr[i*32 +: 32]    = p_addr[i];
         req_wdata[i*32 +: 32]   = p_wdata[i];
      end
   endtask

   task automatic step();
      int            win, j, w;
      bit            arb, rsp_now;
      logic [NR-1:0] eg;
      @(posedge PCLK);
      #1;
      cyc++;
      for (int i = 0; i < NR; i++) begin
         if (!pend[i] && ($urandom_range(99) < req_pct)) begin
            pend[i]    = 1'b1;
            p_wr[i]    = ($urandom_range(1) != 0);
            p_addr[i]  = $urandom;
            p_wdata[i] = $urandom;
         end
      end
      drive_req();
      PRESET = rst_now;
      PRDATA = $urandom;
      if (busy && cyc >= g_cyc + 2) begin
         PREADY  = !to_x && (cyc == end_cyc);
         PSLVERR = force_err || ($urandom_range(1) != 0);
      end else begin
         PREADY  = ($urandom_range(1) != 0);
         PSLVERR = ($urandom_range(1) != 0);
      end

      @(negedge PCLK);
      chk("psel",    32'(PSEL),    32'(busy && cyc >= g_cyc + 1));
      chk("penable", 32'(PENABLE), 32'(busy && cyc >= g_cyc + 2));
      chk("paddr",   PADDR,        sh_addr);
      chk("pwrite",  32'(PWRITE),  32'(sh_wr));
      chk("pwdata",  PWDATA,       sh_wdata);
      rsp_now = rsp_due && (cyc == rsp_cyc);
      chk("rsp_valid",   32'(rsp_valid),   rsp_now ? (32'd1 << rsp_own) : 32'd0);
      chk("timeout_evt", 32'(timeout_evt), 32'(rsp_now && rsp_t));
      if (rsp_now) begin
         chk("rsp_err",   32'(rsp_err), 32'(rsp_e));
         chk("rsp_rdata", rsp_rdata,    rsp_d);
         rsp_due = 1'b0;
      end

      arb = !rst_now && (!busy || (cyc == end_cyc && !to_x));
      win = -1;
      if (arb) begin
         for (int k = 0; k < NR; k++) begin
            j = (rr + k) % NR;
            if (win < 0 && pend[j]) win = j;
         end
      end
      eg = '0;
      if (win >= 0) eg = NR'(1) << win;
      chk("req_gnt", 32'(req_gnt), 32'(eg));

      if (rst_now) begin
         busy = 1'b0; rsp_due = 1'b0; rr = 0;
         sh_addr = '0; sh_wdata = '0; sh_wr = 1'b0;
      end else begin
         if (busy && cyc == end_cyc) begin
            rsp_due = 1'b1;
            rsp_cyc = cyc + 1;
            rsp_own = own;
            rsp_t   = to_x;
            rsp_e   = to_x ? 1'b1 : PSLVERR;
            rsp_d   = (to_x || x_wr) ? 32'h0 : PRDATA;
            busy    = 1'b0;
         end
         if (win >= 0) begin
            busy     = 1'b1;
            g_cyc    = cyc;
            own      = win;
            x_wr     = p_wr[win];
            sh_wr    = p_wr[win];
            sh_addr  = p_addr[win];
            sh_wdata = p_wdata[win];
            pend[win] = 1'b0;
            rr       = (win + 1) % NR;
            w        = (wait_q.size() > 0) ? wait_q.pop_front() : rand_wait();
            to_x     = (w >= TO);
            end_cyc  = g_cyc + 2 + (to_x ? TO - 1 : w);
         end
      end
   endtask

   task automatic set_req(input int i, input bit wr, input logic [31:0] a, input logic [31:0] d);
      pend[i] = 1'b1; p_wr[i] = wr; p_addr[i] = a; p_wdata[i] = d;
   endtask

   initial begin
      for (int i = 0; i < NR; i++) begin
         pend[i] = 1'b0; p_wr[i] = 1'b0; p_addr[i] = '0; p_wdata[i] = '0;
      end
      busy = 1'b0; rsp_due = 1'b0; rr = 0; to_x = 1'b0; x_wr = 1'b0;
      g_cyc = 0; end_cyc = 0; own = 0; rsp_cyc = 0; rsp_own = 0;
      rsp_t = 1'b0; rsp_e = 1'b0; rsp_d = '0;
      sh_addr = '0; sh_wdata = '0; sh_wr = 1'b0;
      req_pct = 0; force_err = 1'b0; rst_now = 1'b0;
      PRESET = 1'b1; PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = '0;
      drive_req();
      repeat (2) @(posedge PCLK);

      // Reset state, idle bus.
      step();

      // Zero-wait write from requester 0.
      set_req(0, 1'b1, 32'h4000_0010, 32'hDEAD_BEEF);
      wait_q.push_back(0);
      repeat (5) step();

      // Read with two wait states from requester 2.
      set_req(2, 1'b0, 32'h8000_0004, 32'h0);
      wait_q.push_back(2);
      repeat (7) step();

      // Full contention from rr_ptr=0: grants 0,1,2,3 back-to-back.
      rst_now = 1'b1; step(); rst_now = 1'b0;
      for (int i = 0; i < NR; i++) set_req(i, (i % 2) == 0, 32'h1000_0000 + 32'(i * 4), 32'hA5A5_0000 + 32'(i));
      repeat (NR) wait_q.push_back(0);
      repeat (12) step();

      // Slave error on a read; the queued request is still granted.
      force_err = 1'b1;
      set_req(1, 1'b0, 32'h2000_0040, 32'h0);
      set_req(2, 1'b1, 32'h2000_0044, 32'h0BAD_F00D);
      wait_q.push_back(0); wait_q.push_back(1);
      repeat (9) step();
      force_err = 1'b0;

      // Hung slave: timeout, then a normal transfer.
      set_req(3, 1'b0, 32'h3000_0000, 32'h0);
      set_req(0, 1'b1, 32'h3000_0004, 32'h5555_AAAA);
      wait_q.push_back(TO + 3); wait_q.push_back(0);
      repeat (30) step();

      // Reset in the middle of ACCESS; rr_ptr returns to 0 so req1 wins over req3.
      set_req(2, 1'b0, 32'h7000_0000, 32'h0);
      wait_q.push_back(10);
      repeat (4) step();
      set_req(1, 1'b1, 32'h7000_0010, 32'h1111_2222);
      set_req(3, 1'b0, 32'h7000_0020, 32'h0);
      rst_now = 1'b1; step(); rst_now = 1'b0;
      wait_q.delete();
      wait_q.push_back(0); wait_q.push_back(0);
      repeat (10) step();

      // Random traffic.
      req_pct = 35;
      repeat (1500) step();
      req_pct = 0;
      repeat (80) step();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/apb_master_arbiter.md
Name: apb_master_arbiter

Overview:
- Shares one APB master port between NUM_REQ internal requesters.
- Runs the APB SETUP/ACCESS sequence for each granted transfer and returns the response to the owning requester.
- Sits upstream of the APB address-decode interconnect: it drives PSEL/PENABLE/PADDR/PWRITE/PWDATA and consumes the muxed PREADY/PRDATA/PSLVERR.
- Round-robin fairness between requesters; a wait-state timeout guards against a hung slave.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT_CYCLES, 16, max ACCESS cycles with PREADY=0 before forced termination; 0 disables the timeout.

Ports:
- PCLK  in  1  clock.
- PRESET  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request; held high until granted.
- req_write  in  NUM_REQ  1=write, 0=read.
- req_addr  in  NUM_REQ x 32  request address.
- req_wdata  in  NUM_REQ x 32  write data.
- req_gnt  out  NUM_REQ  one-hot, 1-cycle pulse; request fields are captured on this edge.
- rsp_valid  out  NUM_REQ  one-hot, 1-cycle completion pulse to the owner.
- rsp_rdata  out  32  read data, valid with rsp_valid.
- rsp_err  out  1  error flag (PSLVERR or timeout), valid with rsp_valid.
- timeout_evt  out  1  1-cycle pulse on timeout termination.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PADDR  out  32  APB address.
- PWRITE  out  1  APB direction.
- PWDATA  out  32  APB write data.
- PREADY  in  1  from interconnect.
- PRDATA  in  32  from interconnect.
- PSLVERR  in  1  from interconnect.

Behaviour:
- Everything is clocked on PCLK rising edge. PRESET is sampled synchronously.
- Reset:
  - state=IDLE; rr_ptr=0; timeout counter=0.
  - All outputs 0.
  - Reset mid-transfer: PSEL/PENABLE low the cycle after reset is sampled; no rsp_valid is issued for the aborted transfer.
- FSM states: IDLE, SETUP, ACCESS.
- Arbitration point: any cycle in IDLE, or the ACCESS cycle where PREADY=1.
  - Winner = first asserted req_valid, searching from rr_ptr upward with wrap-around at NUM_REQ-1 -> 0.
  - req_gnt[winner]=1 combinationally in that cycle.
  - addr/write/wdata/owner are registered on that edge.
  - rr_ptr <= (winner+1) mod NUM_REQ.
  - No request pending: no grant, and rr_ptr is unchanged.
- IDLE:
  - Grant -> SETUP; otherwise stay in IDLE.
  - PSEL=0, PENABLE=0.
- SETUP (exactly 1 cycle):
  - PSEL=1, PENABLE=0.
  - PADDR/PWRITE/PWDATA come from the captured registers.
  - Always -> ACCESS.
- ACCESS:
  - PSEL=1, PENABLE=1, address/control/data held stable.
  - PREADY=0: stay; counter increments.
  - PREADY=1: transfer completes; counter clears.
    - Next cycle: rsp_valid[owner]=1; rsp_err=PSLVERR sampled at completion.
    - rsp_rdata = PRDATA sampled for reads, 0 for writes.
    - If a grant occurs in the completion cycle -> SETUP (PSEL stays 1 back-to-back, PENABLE drops to 0). Otherwise -> IDLE.
- Timeout (TIMEOUT_CYCLES>0):
  - Triggers when the counter reaches TIMEOUT_CYCLES in ACCESS with PREADY still 0.
  - Transfer is terminated; next state IDLE (no arbitration in that cycle).
  - Next cycle: rsp_valid[owner]=1, rsp_err=1, rsp_rdata=0, timeout_evt=1.
  - PREADY=1 in the same cycle the count is reached counts as normal completion; there is no timeout.
- Latency, zero wait states: grant cycle G, SETUP G+1, ACCESS G+2, rsp_valid G+3. Each PREADY wait adds 1 cycle.
- Max throughput: one transfer per 2 cycles with back-to-back grants.
- Outputs in IDLE: PADDR/PWRITE/PWDATA hold their last values; only PSEL and PENABLE are guaranteed 0.
- Error propagation: PSLVERR is only meaningful when PREADY=1 and is ignored otherwise.
- Fairness: a continuously asserted requester waits at most NUM_REQ-1 transfers before being granted.

Test Plan:
- Write, zero wait: req0 write addr 0x4000_0010, wdata 0xDEAD_BEEF, PREADY=1 -> req_gnt[0] at cycle G; SETUP at G+1; ACCESS at G+2 with PADDR/PWDATA correct; rsp_valid[0] at G+3, rsp_err=0.
- Read, 2 wait states: req2 read 0x8000_0004, PREADY low 2 cycles, PRDATA=0x1234_5678 -> PSEL/PENABLE held 3 ACCESS cycles; rsp_valid[2] at G+5, rsp_rdata=0x1234_5678.
- Contention: all 4 req_valid high with rr_ptr=0 -> grants in order 0,1,2,3, back-to-back; PSEL never drops between transfers; PENABLE=0 exactly 1 cycle each; final rr_ptr=0.
- Slave error: read with PREADY=1, PSLVERR=1 -> rsp_err=1 on the owner's rsp_valid; the next queued request is still granted.
- Timeout: TIMEOUT_CYCLES=16, PREADY stuck 0 -> after 16 ACCESS cycles PSEL=0, state IDLE; rsp_valid with rsp_err=1, rsp_rdata=0, timeout_evt pulse; a subsequent request completes normally.
- Reset mid-ACCESS: assert PRESET for 1 cycle during ACCESS -> PSEL=PENABLE=0 next cycle, no rsp_valid, rr_ptr=0; a pending req1 is granted first after reset.
